// File: rtl/sha_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sha_pkg
// Description : Shared constants and the arbiter state encoding for the
//               SHA-256 core arbiter slice.
// Revision    : 1.0 - initial release
// ============================================================================
package sha_pkg;

    localparam int c_BLK_W  = 512;   // SHA-256 message block width
    localparam int c_HASH_W = 256;   // SHA-256 digest width

    // Arbiter states, explicitly encoded on 2 bits
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_GRANT     = 2'd1,
        ST_WAIT_HASH = 2'd2,
        ST_DELIVER   = 2'd3
    } arb_state_t;

endpackage : sha_pkg
`default_nettype wire

// File: rtl/sha_core_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin select. Returns the first index
//               >= i_ptr whose request bit is set, wrapping past NUM_REQ-1.
// Ports       : i_req  - request vector
//               i_ptr  - round-robin start index
//               o_idx  - winning index (valid when o_any)
//               o_any  - at least one request set
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    // Rotating the doubled vector right by i_ptr puts requester i_ptr at
    // bit 0, so the lowest set bit of w_rot is the distance to the winner.
    logic [NUM_REQ-1:0] w_rot;
    int                 w_sum;

    assign w_rot = NUM_REQ'({i_req, i_req} >> i_ptr);
    assign o_any = |i_req;

    always_comb begin
        w_sum = 0;
        // Scan downward so the lowest set bit is the last one written
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_sum = int'(i_ptr) + i;
            end
        end
        if (w_sum >= NUM_REQ) begin
            w_sum = w_sum - NUM_REQ;
        end
        o_idx = IDX_W'(w_sum);
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/sha_core_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sha_core_arbiter
// Description : Shares one SHA-256 core between NUM_REQ requesters. A grant
//               covers a whole message (all blocks through the last one);
//               the digest is returned to the owner before the next grant.
// Ports       : req_blk_*  - per-requester block input (valid/rdy/last)
//               core_blk_* - block stream to the SHA core
//               hash_*     - digest from the SHA core
//               resp_*     - digest back to the owner (one-hot valid)
//               owner      - current/last owner index (debug)
// Options     : SHA_ARB_TIMEOUT_EN - abort WAIT_HASH after TIMEOUT_CYC
//               cycles, delivering resp_data=0 with resp_err=1.
// Revision    : 1.0 - initial release
// ============================================================================
module sha_core_arbiter
    import sha_pkg::*;
#(
    parameter  int NUM_REQ     = 4,
    parameter  int BLK_W       = c_BLK_W,
    parameter  int HASH_W      = c_HASH_W,
    parameter  int TIMEOUT_CYC = 1024,
    localparam int OWN_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ*BLK_W-1:0] req_blk_data,
    input  logic [NUM_REQ-1:0]       req_blk_last,
    input  logic [NUM_REQ-1:0]       req_blk_valid,
    output logic [NUM_REQ-1:0]       req_blk_rdy,
    output logic [BLK_W-1:0]         core_blk_data,
    output logic                     core_blk_last,
    output logic                     core_blk_valid,
    input  logic                     core_blk_rdy,
    input  logic [HASH_W-1:0]        hash_data,
    input  logic                     hash_valid,
    output logic                     hash_rdy,
    output logic [HASH_W-1:0]        resp_data,
    output logic [NUM_REQ-1:0]       resp_valid,
    input  logic [NUM_REQ-1:0]       resp_rdy,
    output logic                     resp_err,
    output logic [OWN_W-1:0]         owner
);

    if (NUM_REQ < 1 || NUM_REQ > 16) begin : g_bad_num_req
        $error("sha_core_arbiter: NUM_REQ must be 1..16");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("sha_core_arbiter: TIMEOUT_CYC must be >= 1");
    end

    arb_state_t          state_q, state_d;
    logic [OWN_W-1:0]    owner_q, owner_d;
    logic [OWN_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic                hash_rdy_q, hash_rdy_d;
    logic [HASH_W-1:0]   resp_data_q, resp_data_d;
    logic                resp_err_q, resp_err_d;
    logic [OWN_W-1:0]    w_pick_idx;
    logic                w_pick_any;
    logic [OWN_W-1:0]    w_owner_next;
    logic                w_blk_xfer;

`ifdef SHA_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0]    cnt_q, cnt_d;
`endif

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (OWN_W)
    ) u_rr_pick (
        .i_req (req_blk_valid),
        .i_ptr (rr_ptr_q),
        .o_idx (w_pick_idx),
        .o_any (w_pick_any)
    );

    // Block path is a pure mux from the owner; only valid is state-gated
    assign core_blk_data  = req_blk_data[owner_q*BLK_W +: BLK_W];
    assign core_blk_last  = req_blk_last[owner_q];
    assign core_blk_valid = (state_q == ST_GRANT) && req_blk_valid[owner_q];
    assign w_blk_xfer     = core_blk_valid && core_blk_rdy;

    // Successor of the owner, wrapping at NUM_REQ (stays 0 for one requester)
    assign w_owner_next = (int'(owner_q) >= NUM_REQ - 1) ? '0 : owner_q + OWN_W'(1);

    always_comb begin
        req_blk_rdy = '0;
        resp_valid  = '0;
        if (state_q == ST_GRANT) begin
            req_blk_rdy[owner_q] = core_blk_rdy;
        end
        if (state_q == ST_DELIVER) begin
            resp_valid[owner_q] = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        hash_rdy_d  = hash_rdy_q;
        resp_data_d = resp_data_q;
        resp_err_d  = resp_err_q;
`ifdef SHA_ARB_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (w_pick_any) begin
                    owner_d = w_pick_idx;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // Lock is held across gaps in the owner's valid
                if (w_blk_xfer && core_blk_last) begin
                    state_d    = ST_WAIT_HASH;
                    hash_rdy_d = 1'b1;
`ifdef SHA_ARB_TIMEOUT_EN
                    cnt_d      = '0;
`endif
                end
            end
            ST_WAIT_HASH: begin
`ifdef SHA_ARB_TIMEOUT_EN
                cnt_d = cnt_q + CNT_W'(1);
`endif
                // A digest arriving on the expiry cycle takes precedence
                if (hash_valid) begin
                    resp_data_d = hash_data;
                    resp_err_d  = 1'b0;
                    hash_rdy_d  = 1'b0;
                    state_d     = ST_DELIVER;
                end
`ifdef SHA_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    resp_data_d = '0;
                    resp_err_d  = 1'b1;
                    hash_rdy_d  = 1'b0;
                    state_d     = ST_DELIVER;
                end
`endif
            end
            ST_DELIVER: begin
                if (resp_rdy[owner_q]) begin
                    resp_err_d = 1'b0;
                    rr_ptr_d   = w_owner_next;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            hash_rdy_q  <= 1'b0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
`ifdef SHA_ARB_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            hash_rdy_q  <= hash_rdy_d;
            resp_data_q <= resp_data_d;
            resp_err_q  <= resp_err_d;
`ifdef SHA_ARB_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign hash_rdy  = hash_rdy_q;
    assign resp_data = resp_data_q;
    assign resp_err  = resp_err_q;
    assign owner     = owner_q;

endmodule : sha_core_arbiter
`default_nettype wire

// File: tb/tb_sha_core_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sha_core_arbiter
// Description : Self-checking bench for sha_core_arbiter (NUM_REQ=4). The
//               bench models the requesters and the SHA core; expected
//               owners and digests are queued when stimulus is created and
//               compared when the arbiter produces output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sha_core_arbiter;

    localparam int N  = 4;
    localparam int BW = 512;
    localparam int HW = 256;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N*BW-1:0] req_blk_data;
    logic [N-1:0]    req_blk_last;
    logic [N-1:0]    req_blk_valid;
    logic [N-1:0]    req_blk_rdy;
    logic [BW-1:0]   core_blk_data;
    logic            core_blk_last;
    logic            core_blk_valid;
    logic            core_blk_rdy;
    logic [HW-1:0]   hash_data;
    logic            hash_valid;
    logic            hash_rdy;
    logic [HW-1:0]   resp_data;
    logic [N-1:0]    resp_valid;
    logic [N-1:0]    resp_rdy;
    logic            resp_err;
    logic [1:0]      owner;

    always #5 clk = ~clk;

    sha_core_arbiter #(
        .NUM_REQ     (N),
        .BLK_W       (BW),
        .HASH_W      (HW),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_blk_data   (req_blk_data),
        .req_blk_last   (req_blk_last),
        .req_blk_valid  (req_blk_valid),
        .req_blk_rdy    (req_blk_rdy),
        .core_blk_data  (core_blk_data),
        .core_blk_last  (core_blk_last),
        .core_blk_valid (core_blk_valid),
        .core_blk_rdy   (core_blk_rdy),
        .hash_data      (hash_data),
        .hash_valid     (hash_valid),
        .hash_rdy       (hash_rdy),
        .resp_data      (resp_data),
        .resp_valid     (resp_valid),
        .resp_rdy       (resp_rdy),
        .resp_err       (resp_err),
        .owner          (owner)
    );

    typedef struct {
        int          req;
        int          nblk;
        int          cstall;
        int          rstall;
        int          hdelay;
        int          exp_own;
        logic [255:0] hash;
    } vec_t;

    typedef struct {
        int           own;
        logic [255:0] dig;
        logic         err;
    } resp_t;

    // Requester block queues (index-based), expected owners and responses
    logic [511:0] bq_data [N][32];
    logic         bq_last [N][32];
    int           bq_rd [N];
    int           bq_wr [N];
    int           own_q[$];
    resp_t        resp_q[$];

    logic [N-1:0] hold;
    int           core_stall, resp_stall, hash_delay, hwait_cnt;
    bit           pend, hash_silent, spur_hash;
    logic [255:0] pend_hash;
    int           n_vec, n_bad;
    vec_t         tbl [6];

    // The core model's digest: xor of the two halves of the last block
    function automatic logic [255:0] dig_of(input logic [511:0] b);
        return b[511:256] ^ b[255:0];
    endfunction

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] m;
        m = '0;
        if (i >= 0 && i < N) m[i] = 1'b1;
        return m;
    endfunction

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic clear_bench();
        for (int i = 0; i < N; i++) begin
            bq_rd[i] = 0;
            bq_wr[i] = 0;
        end
        own_q.delete();
        resp_q.delete();
        hold        = '0;
        core_stall  = 0;
        resp_stall  = 0;
        hash_delay  = 0;
        pend        = 1'b0;
        hash_silent = 1'b0;
        spur_hash   = 1'b0;
    endtask

    // Queue an nblk-block message on requester r whose digest will be h
    task automatic push_msg(input int r, input int nblk, input logic [255:0] h);
        logic [255:0] a, b;
        for (int k = 0; k < nblk; k++) begin
            for (int j = 0; j < 8; j++) begin
                a[j*32 +: 32] = $urandom();
                b[j*32 +: 32] = $urandom();
            end
            if (k == nblk - 1) b = a ^ h;
            bq_data[r][bq_wr[r]] = {a, b};
            bq_last[r][bq_wr[r]] = (k == nblk - 1);
            bq_wr[r]++;
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (bq_rd[i] < bq_wr[i]) begin
                req_blk_valid[i]          = !hold[i];
                req_blk_data[i*BW +: BW]  = bq_data[i][bq_rd[i]];
                req_blk_last[i]           = bq_last[i][bq_rd[i]];
            end else begin
                req_blk_valid[i]          = 1'b0;
                req_blk_data[i*BW +: BW]  = '0;
                req_blk_last[i]           = 1'b0;
            end
        end
        core_blk_rdy = (core_stall == 0);
        if (pend) begin
            hash_valid = (hash_delay == 0) && !hash_silent;
            hash_data  = pend_hash;
        end else begin
            // Junk digest offered outside WAIT_HASH must be ignored
            hash_valid = spur_hash;
            hash_data  = {8{32'hDEADBEEF}};
        end
        // While stalling, non-owners assert rdy: the arbiter must ignore them
        resp_rdy = (resp_stall > 0) ? ~resp_valid : '1;
    endtask

    // One clock: drive, check settled outputs, advance, update models
    task automatic cycle();
        int           eo;
        logic [N-1:0] req_hs, m;
        bit           core_hs, hash_hs, resp_hs, cv, rv;
        logic [511:0] cur_blk;
        logic         cur_last;
        drive();
        #1;
        eo       = (own_q.size() > 0) ? own_q[0] : -1;
        cur_blk  = '0;
        cur_last = 1'b0;
        if (hash_rdy) hwait_cnt++;
        m = req_blk_rdy & ~onehot(eo);
        chk("req_blk_rdy_nonowner", m, '0);
        if (core_blk_valid) begin
            if (eo < 0 || bq_rd[eo] >= bq_wr[eo]) begin
                chk("core_blk_valid_unexpected", core_blk_valid, 1'b0);
            end else begin
                cur_blk  = bq_data[eo][bq_rd[eo]];
                cur_last = bq_last[eo][bq_rd[eo]];
                chk("owner", owner, eo);
                chk("core_blk_data", core_blk_data, cur_blk);
                chk("core_blk_last", core_blk_last, cur_last);
            end
        end
        cv      = core_blk_valid;
        core_hs = core_blk_valid && core_blk_rdy;
        for (int i = 0; i < N; i++) req_hs[i] = req_blk_valid[i] && req_blk_rdy[i];
        chk("single_transfer", req_hs, core_hs ? onehot(eo) : '0);
        hash_hs = hash_valid && hash_rdy;
        if (hash_hs && !pend) chk("hash_rdy_outside_wait", hash_rdy, 1'b0);
        rv = (resp_valid != '0);
        if (rv) begin
            if (resp_q.size() == 0) begin
                chk("resp_valid_unexpected", resp_valid, '0);
            end else begin
                chk("resp_valid", resp_valid, onehot(resp_q[0].own));
                chk("resp_data", resp_data, resp_q[0].dig);
                chk("resp_err", resp_err, resp_q[0].err);
            end
        end
        resp_hs = ((resp_valid & resp_rdy) != '0);
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) if (req_hs[i]) bq_rd[i]++;
        if (cv && core_stall > 0) core_stall--;
        if (core_hs && cur_last) begin
            pend      = 1'b1;
            pend_hash = dig_of(cur_blk);
        end else if (hash_hs && pend) begin
            pend = 1'b0;
            resp_q.push_back('{own: eo, dig: pend_hash, err: 1'b0});
        end else if (pend && hash_delay > 0) begin
            hash_delay--;
        end
        if (rv && resp_stall > 0) resp_stall--;
        if (resp_hs) begin
            if (resp_q.size() > 0) void'(resp_q.pop_front());
            if (own_q.size() > 0) void'(own_q.pop_front());
        end
    endtask

    task automatic run_msgs(input int budget, input string nm);
        int c;
        c = 0;
        while (own_q.size() > 0 && c < budget) begin
            cycle();
            c++;
        end
        chk({nm, "_completed"}, own_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec     = 0;
        n_bad     = 0;
        hwait_cnt = 0;
        clear_bench();
        rst_n = 1'b0;
        tbl[0] = '{1, 2, 0, 0, 0, 1, {32{8'hA5}}};
        tbl[1] = '{3, 1, 3, 4, 2, 3, {8{32'h01234567}}};
        tbl[2] = '{0, 3, 1, 0, 5, 0, {16{16'hC3E1}}};
        tbl[3] = '{2, 1, 0, 2, 0, 2, {4{64'hFEDC_BA98_7654_3210}}};
        tbl[4] = '{3, 4, 2, 1, 1, 3, {32{8'h5A}}};
        tbl[5] = '{1, 1, 0, 0, 0, 1, 256'h1};

        // Contention: all four valid at reset release -> order 0,1,2,3,0
        push_msg(0, 1, {8{32'h0000_0A00}});
        push_msg(0, 1, {8{32'h0000_0A01}});
        push_msg(1, 1, {8{32'h0000_0B00}});
        push_msg(2, 1, {8{32'h0000_0C00}});
        push_msg(3, 1, {8{32'h0000_0D00}});
        own_q = '{0, 1, 2, 3, 0};
        drive();
        repeat (3) @(posedge clk);
        #1;
        drive();
        #1;
        chk("rst_req_blk_rdy", req_blk_rdy, '0);
        chk("rst_core_blk_valid", core_blk_valid, 1'b0);
        chk("rst_hash_rdy", hash_rdy, 1'b0);
        chk("rst_resp_valid", resp_valid, '0);
        chk("rst_resp_data", resp_data, '0);
        chk("rst_resp_err", resp_err, 1'b0);
        chk("rst_owner", owner, 0);
        rst_n = 1'b1;
        run_msgs(400, "contention");

        // Table: single messages with assorted stalls and digest latency
        for (int v = 0; v < 6; v++) begin
            clear_bench();
            push_msg(tbl[v].req, tbl[v].nblk, tbl[v].hash);
            own_q.push_back(tbl[v].exp_own);
            core_stall = tbl[v].cstall;
            resp_stall = tbl[v].rstall;
            hash_delay = tbl[v].hdelay;
            run_msgs(300, "vector");
        end

        // Lock hold: req0 pauses 5 cycles mid-message while req2 waits
        clear_bench();
        spur_hash = 1'b1;
        push_msg(0, 3, {8{32'h1357_9BDF}});
        own_q.push_back(0);
        for (int c = 0; c < 50 && bq_rd[0] < 1; c++) cycle();
        chk("lock_first_block", bq_rd[0], 1);
        hold[0] = 1'b1;
        push_msg(2, 1, {8{32'h2468_ACE0}});
        own_q.push_back(2);
        repeat (5) begin
            cycle();
            chk("lock_owner", owner, 0);
            chk("lock_core_blk_valid", core_blk_valid, 1'b0);
        end
        hold[0] = 1'b0;
        run_msgs(300, "lock");
        spur_hash = 1'b0;

        // Async reset in WAIT_HASH; rr_ptr would be 3, reset makes it 0
        clear_bench();
        push_msg(2, 1, {8{32'h7777_0002}});
        own_q.push_back(2);
        run_msgs(200, "pre_reset");
        push_msg(1, 1, {8{32'h7777_0001}});
        own_q.push_back(1);
        hash_delay = 50;
        for (int c = 0; c < 50 && !hash_rdy; c++) cycle();
        chk("reached_wait_hash", hash_rdy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_hash_rdy", hash_rdy, 1'b0);
        chk("arst_core_blk_valid", core_blk_valid, 1'b0);
        chk("arst_req_blk_rdy", req_blk_rdy, '0);
        chk("arst_resp_valid", resp_valid, '0);
        chk("arst_resp_data", resp_data, '0);
        chk("arst_owner", owner, 0);
        clear_bench();
        push_msg(3, 1, {8{32'h8888_0003}});
        push_msg(0, 1, {8{32'h8888_0000}});
        own_q = '{0, 3};
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_msgs(300, "post_reset");

`ifdef SHA_ARB_TIMEOUT_EN
        // Silent core: DELIVER after 16 WAIT_HASH cycles, zero data, error
        clear_bench();
        push_msg(2, 1, {8{32'h9999_0002}});
        own_q.push_back(2);
        resp_q.push_back('{own: 2, dig: '0, err: 1'b1});
        hash_silent = 1'b1;
        hwait_cnt   = 0;
        run_msgs(100, "timeout");
        chk("timeout_wait_cycles", hwait_cnt, 16);
        clear_bench();
        drive();
        #1;
        chk("timeout_err_cleared", resp_err, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_sha_core_arbiter
`default_nettype wire

// File: doc/sha_core_arbiter.md
Name: sha_core_arbiter

Overview:
Shares one SHA-256 core between NUM_REQ requesters. Round-robin arbitration at message granularity: a granted requester owns the core for every 512-bit block up to and including its last block. The block then waits for the 256-bit digest on the core's hash output interface (hash_data/hash_valid/hash_rdy). The digest is returned to the owning requester before the next grant. Sits between the requester ports and the SHA core input/output interfaces.

Parameters:
NUM_REQ, 4, number of requesters (1..16)
BLK_W, 512, message block width
HASH_W, 256, digest width
TIMEOUT_CYC, 1024, cycles allowed in WAIT_HASH (used only with SHA_ARB_TIMEOUT_EN)

Ports:
clk  in  1  single clock; all logic on rising edge
rst_n  in  1  asynchronous, active-low reset
req_blk_data  in  NUM_REQ*BLK_W  per-requester block data, requester i at [i*BLK_W +: BLK_W]
req_blk_last  in  NUM_REQ  block is final block of message
req_blk_valid  in  NUM_REQ  block offered
req_blk_rdy  out  NUM_REQ  block accepted
core_blk_data  out  BLK_W  block to SHA core
core_blk_last  out  1  final block to core
core_blk_valid  out  1  block offered to core
core_blk_rdy  in  1  core accepts block
hash_data  in  HASH_W  digest from core
hash_valid  in  1  digest valid
hash_rdy  out  1  arbiter accepts digest
resp_data  out  HASH_W  captured digest (shared bus)
resp_valid  out  NUM_REQ  one-hot digest valid to owner
resp_rdy  in  NUM_REQ  requester accepts digest
resp_err  out  1  digest invalid (timeout); 0 without macro
owner  out  $clog2(NUM_REQ) (min 1)  current/last owner index, debug

Behaviour:
- Reset: state IDLE; rr_ptr=0; owner=0; hash_rdy=0; resp_valid=0; resp_data=0; resp_err=0; req_blk_rdy=0; core_blk_valid=0. Reset mid-message discards the in-flight message; the core is reset by the same rst_n.
- IDLE: if any req_blk_valid, register the winner and go to GRANT. Winner is the first requester index >= rr_ptr with valid set, wrapping from NUM_REQ-1 to 0. Grant latency: 1 cycle. No valid: stay in IDLE.
- GRANT:
  - core_blk_data/last/valid are combinationally muxed from the owner.
  - req_blk_rdy[owner] = core_blk_rdy; all other req_blk_rdy are 0.
  - Transfer occurs on core_blk_valid && core_blk_rdy.
  - Transfer with last=1: go to WAIT_HASH.
  - Owner deasserting valid mid-message: lock is held, no re-arbitration.
- WAIT_HASH: hash_rdy=1 (registered, asserted the cycle state enters). On hash_valid: capture hash_data into resp_data, go to DELIVER. hash_valid outside WAIT_HASH is ignored (hash_rdy=0).
- DELIVER:
  - resp_valid[owner]=1; resp_data is held stable.
  - On resp_rdy[owner]: resp_valid=0; rr_ptr=(owner+1) mod NUM_REQ; go to IDLE.
  - resp_rdy of non-owners is ignored.
- Minimum turnaround between messages from different requesters: 1 IDLE cycle.
- NUM_REQ=1: rr_ptr stays 0, behaviour otherwise identical.
- Simultaneous requests in IDLE are resolved by rr_ptr only; the last-flag state of the losers is irrelevant.

Optional Feature:
SHA_ARB_TIMEOUT_EN:
- With the macro: a counter clears on entry to WAIT_HASH and increments each cycle there. On reaching TIMEOUT_CYC without hash_valid, the block goes to DELIVER with resp_data=0 and resp_err=1. resp_err clears on the resp handshake. hash_valid in the same cycle as expiry wins: normal capture, resp_err=0.
- Without the macro: no counter; WAIT_HASH waits indefinitely; resp_err is tied 0.

Decomposition:
- Package sha_pkg: BLK_W/HASH_W constants; state enum (IDLE, GRANT, WAIT_HASH, DELIVER).
- Sub-module rr_pick: combinational round-robin priority select (req vector, rr_ptr -> winner index, any).

Test Plan:
- Single message: req1 sends 2 blocks (second last=1); core returns hash 256'hA5...A5 -> resp_valid=4'b0010, resp_data=A5..A5; req_blk_rdy[0,2,3] stay 0 throughout.
- Contention: all 4 requesters valid at reset release -> service order 0,1,2,3,0; rr_ptr wraps 3->0.
- Lock hold: req0 deasserts valid for 5 cycles mid-message while req2 is valid -> owner stays 0; no core_blk_valid from req2 until req0's digest handshakes.
- Backpressure: core_blk_rdy low 3 cycles, then resp_rdy low 4 cycles -> data and resp_data held stable, single transfer per handshake.
- Async reset asserted in WAIT_HASH -> all outputs 0 immediately; next grant goes to req0.
- SHA_ARB_TIMEOUT_EN, TIMEOUT_CYC=16, core silent -> DELIVER after 16 WAIT_HASH cycles with resp_err=1, resp_data=0.
